stream_fifo_flushable: RTL

- Parameterised valid/ready stream FIFO with synchronous flush and fill-level output.
- Sits on the receiving end of a stream channel in the AXI cut/buffer path.
- Absorbs bursts that a 2-entry spill stage cannot hold, and decouples the upstream ready from downstream ready.
- Outputs come from storage state only, so both the valid and ready timing paths are cut; the optional fall-through mode is the exception.

---
 rtl/stream_fifo_flushable.sv | 80 ++++++++
 1 files changed

// File: rtl/stream_fifo_flushable.sv
// Valid/ready stream FIFO with synchronous flush and fill-level output.
// Define STREAM_FIFO_FALL_THROUGH_EN for zero-latency pass-through when empty.
module stream_fifo_flushable #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      usage_o
);

  localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty, full, push, pop, bypass;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_FULL);
    ready_o = !flush_i && !full;
    valid_o = !flush_i && !empty;
    data_o  = mem_q[rd_ptr_q];
    bypass  = 1'b0;
`ifdef STREAM_FIFO_FALL_THROUGH_EN
    // Empty FIFO forwards the input; a beat taken downstream is never stored.
    if (empty && !flush_i) begin
      valid_o = valid_i;
      data_o  = data_i;
      bypass  = valid_i && ready_i;
    end
`endif
    push = valid_i && ready_o && !bypass;
    pop  = valid_o && ready_i && !empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign usage_o = count_q;

endmodule
